alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: instruction on in_instr is valid.
REQ-004 SHALL have port in_instr, input, 16 bits: fields [15:12] op, [11:9] rd index, [8:6] rs index, [8:0] LDI immediate, [3:0] shift amount.
REQ-005 SHALL have port in_ready, output, 1 bit: sequencer can accept an instruction.
REQ-006 SHALL have port alu_rd, output, 16 bits: first-operand value to ALU.
REQ-007 SHALL have port alu_rs, output, 16 bits: second-operand value to ALU.
REQ-008 SHALL have port alu_opcode, output, 4 bits: opcode to ALU.
REQ-009 SHALL have port alu_immd, output, 4 bits: shift amount to ALU.
REQ-010 SHALL have port alu_result, input, 16 bits: combinational ALU result.
REQ-011 SHALL have ports alu_carry, alu_overflow, alu_minus and alu_zero, each input, 1 bit: ALU flags.
REQ-012 SHALL have port flags, output, 4 bits: architectural flags {C,V,N,Z}.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse at instruction retirement.
REQ-014 SHALL have port err, output, 1 bit: one-cycle pulse, coincident with done, for illegal opcode.
REQ-015 SHALL have port dbg_addr, input, 3 bits: register-file debug read index.
REQ-016 SHALL have port dbg_data, output, 16 bits: combinational read of register dbg_addr.

Function
REQ-017 SHALL contain an 8 x 16-bit register file r0..r7, all general purpose, r0 writable.
REQ-018 SHALL implement FSM states IDLE, EXEC and WB.
REQ-019 SHALL assert in_ready only in IDLE.
REQ-020 SHALL define handshake as in_valid=1 and in_ready=1 at a rising edge.
REQ-021 SHALL, on handshake, latch op, rd index, rs index, immd, r[rd] and r[rs] into operand registers and go to EXEC.
REQ-022 SHALL drive alu_rd, alu_rs, alu_opcode and alu_immd from the operand registers at all times, changing only on handshake.
REQ-023 SHALL, in EXEC, capture alu_result and the four ALU flags into holding registers and go to WB.
REQ-024 SHALL, in WB, perform writeback per REQ-025..REQ-029, pulse done, and return to IDLE, giving 3 cycles per instruction with done high in the 3rd cycle after the handshake edge.
REQ-025 SHALL, for ops 0000, 0001, 0010, 0011, 0100, 0110, 1000, 1001, 1010 and 1011, write the captured result to r[rd] and load flags with the captured {C,V,N,Z}.
REQ-026 SHALL, for op 0101 (CMP), update flags only, with no register write.
REQ-027 SHALL, for op 0111 (LDI), write {7'b0, instr[8:0]} to r[rd], leave flags unchanged, and ignore ALU outputs.
REQ-028 SHALL, for ops 1100-1111, perform no register write and no flag change, and pulse err together with done.
REQ-029 SHALL, when rd index equals rs index, use the pre-write value as both operands.
REQ-030 SHALL ignore in_valid outside IDLE, with no queuing; the instruction is accepted only once the FSM is back in IDLE.
REQ-031 SHALL make a WB write visible at handshake of the next instruction, so no operand hazard exists.

Reset
REQ-032 SHALL, while rst=1, force the FSM to IDLE, all r0..r7=0, flags=0, all operand registers=0 (so alu_* outputs=0), done=0 and err=0.
REQ-033 SHALL, on reset asserted in EXEC or WB, abort the instruction with no register or flag write and no done.
REQ-034 SHALL assert in_ready=1 in the first cycle after rst deasserts.

Verification
REQ-035 SHALL be verified by: LDI r1,5; LDI r2,3; ADD r1,r2 with ALU model returning 0x0008 and flags 0 -> r1=0x0008, flags=0000, done 3 cycles after each handshake.
REQ-036 SHALL be verified by: CMP r1,r1 with ALU returning 0x0000 and Z=1 -> flags=0001, r1 unchanged, done pulses.
REQ-037 SHALL be verified by: in_instr=0xC000 -> done and err pulse together, register file and flags unchanged.
REQ-038 SHALL be verified by: in_valid held high with 4 queued instructions -> handshakes exactly every 3 cycles, in_ready low in EXEC and WB.
REQ-039 SHALL be verified by: SLL r3 with immd=4 -> during EXEC alu_opcode=1000 and alu_immd=4; r3 receives the model's result.
REQ-040 SHALL be verified by: rst pulsed during EXEC of ADD r1,r2 -> r1=0, flags=0, no done, in_ready=1 after release.

Source files
------------

// File: rtl/alu_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | alu_sequencer: 3-cycle IDLE/EXEC/WB sequencer for an external ALU, 8x16 RF |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module alu_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_instr,
  output logic        in_ready,
  output logic [15:0] alu_rd,
  output logic [15:0] alu_rs,
  output logic [3:0]  alu_opcode,
  output logic [3:0]  alu_immd,
  input  logic [15:0] alu_result,
  input  logic        alu_carry,
  input  logic        alu_overflow,
  input  logic        alu_minus,
  input  logic        alu_zero,
  output logic [3:0]  flags,
  output logic        done,
  output logic        err,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  localparam logic [3:0] OP_CMP = 4'b0101;
  localparam logic [3:0] OP_LDI = 4'b0111;

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [2:0]  rd_idx_q, rd_idx_d;
  logic [8:0]  imm_q, imm_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] res_q, res_d;
  logic [3:0]  cf_q, cf_d;
  logic [3:0]  flags_q, flags_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [15:0] rf_q [8];
  logic [15:0] rf_d [8];

  logic w_hs;
  logic w_illegal;
  logic w_wr_res;
  logic w_wr_flags;

  assign in_ready   = (state_q == S_IDLE);
  assign w_hs       = in_valid && in_ready;
  assign alu_rd     = a_q;
  assign alu_rs     = b_q;
  assign alu_opcode = op_q;
  assign alu_immd   = imm_q[3:0];
  assign flags      = flags_q;
  assign done       = done_q;
  assign err        = err_q;
  assign dbg_data   = rf_q[dbg_addr];

  // Opcode classes: top quarter of the opcode space is reserved/illegal.
  assign w_illegal  = (op_q[3:2] == 2'b11);
  assign w_wr_res   = !w_illegal && (op_q != OP_CMP) && (op_q != OP_LDI);
  assign w_wr_flags = !w_illegal && (op_q != OP_LDI);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_idx_d = rd_idx_q;
    imm_d    = imm_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    cf_d     = cf_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rf_d[i] = rf_q[i];
    end

    case (state_q)
      S_IDLE: begin
        if (w_hs) begin
          op_d     = in_instr[15:12];
          rd_idx_d = in_instr[11:9];
          imm_d    = in_instr[8:0];
          a_d      = rf_q[in_instr[11:9]];
          b_d      = rf_q[in_instr[8:6]];
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        res_d   = alu_result;
        cf_d    = {alu_carry, alu_overflow, alu_minus, alu_zero};
        state_d = S_WB;
      end
      S_WB: begin
        done_d = 1'b1;
        err_d  = w_illegal;
        if (w_wr_res) begin
          rf_d[rd_idx_q] = res_q;
        end
        if (op_q == OP_LDI) begin
          rf_d[rd_idx_q] = {7'b0, imm_q};
        end
        if (w_wr_flags) begin
          flags_d = cf_q;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= 4'b0;
      rd_idx_q <= 3'b0;
      imm_q    <= 9'b0;
      a_q      <= 16'b0;
      b_q      <= 16'b0;
      res_q    <= 16'b0;
      cf_q     <= 4'b0;
      flags_q  <= 4'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        rf_q[i] <= 16'b0;
      end
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_idx_q <= rd_idx_d;
      imm_q    <= imm_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      cf_q     <= cf_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      err_q    <= err_d;
      for (int i = 0; i < 8; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_alu_sequencer: directed scoreboard bench with a behavioural ALU model  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_instr = 16'h0;
  logic        in_ready;
  logic [15:0] alu_rd, alu_rs;
  logic [3:0]  alu_opcode, alu_immd;
  logic [15:0] alu_result;
  logic        alu_carry, alu_overflow, alu_minus, alu_zero;
  logic [3:0]  flags;
  logic        done, err;
  logic [2:0]  dbg_addr = 3'd0;
  logic [15:0] dbg_data;

  alu_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .alu_rd(alu_rd), .alu_rs(alu_rs), .alu_opcode(alu_opcode), .alu_immd(alu_immd),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .alu_minus(alu_minus), .alu_zero(alu_zero), .flags(flags), .done(done), .err(err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #10 clk = ~clk;

  // Returns {C,V,N,Z,result}: 0000 add, 0101 compare, 1000 shift-left, else xor.
  function automatic logic [19:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic [3:0] sh);
    logic [16:0] t;
    logic [15:0] r;
    logic        c, v;
    t = 17'h0; c = 1'b0; v = 1'b0;
    case (op)
      4'h0: begin
        t = {1'b0, a} + {1'b0, b};
        r = t[15:0];
        c = t[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      4'h5: begin
        r = a - b;
        c = (a < b);
      end
      4'h8: r = a << sh;
      default: r = a ^ b;
    endcase
    return {c, v, r[15], (r == 16'h0), r};
  endfunction

  assign {alu_carry, alu_overflow, alu_minus, alu_zero, alu_result} =
      alu_fn(alu_opcode, alu_rd, alu_rs, alu_immd);

  typedef struct {
    logic       err;
    logic [2:0] rd;
    int         due;
  } exp_t;

  exp_t        sb[$];
  int          hs_cyc[$];
  logic [15:0] m_rf [8];
  logic [3:0]  m_flags = 4'h0;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  initial begin
    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_rf(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      chk(tag, dbg_data, m_rf[i]);
    end
    chk({tag, "_flags"}, {12'h0, flags}, {12'h0, m_flags});
  endtask

  // Architectural model update and scoreboard push at the handshake edge.
  task automatic accept(input logic [15:0] ins);
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [19:0] f;
    exp_t        e;
    op = ins[15:12];
    rd = ins[11:9];
    f  = alu_fn(op, m_rf[rd], m_rf[ins[8:6]], ins[3:0]);
    e.err = 1'b0;
    e.rd  = rd;
    e.due = cyc + 2;
    case (op)
      4'h5: m_flags = f[19:16];
      4'h7: m_rf[rd] = {7'b0, ins[8:0]};
      4'hC, 4'hD, 4'hE, 4'hF: e.err = 1'b1;
      default: begin
        m_rf[rd] = f[15:0];
        m_flags  = f[19:16];
      end
    endcase
    sb.push_back(e);
    hs_cyc.push_back(cyc);
  endtask

  task automatic tick();
    logic        hs;
    logic [15:0] ins;
    exp_t        e;
    hs  = in_valid && in_ready;
    ins = in_instr;
    @(posedge clk);
    cyc++;
    #1;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("done", {15'h0, done}, 16'd1);
      chk("err", {15'h0, err}, {15'h0, e.err});
      dbg_addr = e.rd;
      #1;
      chk("rd_value", dbg_data, m_rf[e.rd]);
      chk("flags", {12'h0, flags}, {12'h0, m_flags});
    end else begin
      chk("done_quiet", {15'h0, done}, 16'd0);
      chk("err_quiet", {15'h0, err}, 16'd0);
    end
    if (hs) accept(ins);
    chk("in_ready", {15'h0, in_ready}, {15'h0, (sb.size() == 0)});
  endtask

  task automatic send(input logic [15:0] ins);
    int n0;
    int k;
    n0 = hs_cyc.size();
    k  = 0;
    in_valid = 1'b1;
    in_instr = ins;
    while (hs_cyc.size() == n0 && k < 12) begin
      tick();
      k++;
    end
    in_valid = 1'b0;
    chk("handshake_seen", {15'h0, (hs_cyc.size() != n0)}, 16'd1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() > 0 && k < 12) begin
      tick();
      k++;
    end
    chk("drained", {15'h0, (sb.size() == 0)}, 16'd1);
  endtask

  function automatic logic [15:0] ins_rr(input logic [3:0] op, input logic [2:0] rd,
                                         input logic [2:0] rs, input logic [3:0] sh);
    return {op, rd, rs, 2'b00, sh};
  endfunction

  function automatic logic [15:0] ins_ldi(input logic [2:0] rd, input logic [8:0] imm);
    return {4'h7, rd, imm};
  endfunction

  initial begin
    logic [15:0] stream [4];
    int          base;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {15'h0, in_ready}, 16'd1);
    chk("rst_done", {15'h0, done}, 16'd0);
    chk("rst_err", {15'h0, err}, 16'd0);
    chk("rst_alu_rd", alu_rd, 16'h0);
    chk("rst_alu_rs", alu_rs, 16'h0);
    chk("rst_alu_op", {12'h0, alu_opcode}, 16'h0);
    chk("rst_alu_immd", {12'h0, alu_immd}, 16'h0);
    check_rf("rst_rf");
    rst = 1'b0;
    tick();

    // LDI r1,5; LDI r2,3; ADD r1,r2
    send(ins_ldi(3'd1, 9'd5));
    drain();
    send(ins_ldi(3'd2, 9'd3));
    drain();
    send(ins_rr(4'h0, 3'd1, 3'd2, 4'd0));
    drain();
    dbg_addr = 3'd1;
    #1;
    chk("add_r1_const", dbg_data, 16'h0008);
    chk("add_flags_const", {12'h0, flags}, 16'h0);
    check_rf("add_rf");

    // CMP r1,r1: flags only
    send(ins_rr(4'h5, 3'd1, 3'd1, 4'd0));
    drain();
    chk("cmp_flags_const", {12'h0, flags}, 16'h0001);
    check_rf("cmp_rf");

    // Illegal opcode
    send(16'hC000);
    drain();
    check_rf("illegal_rf");

    // SLL r3 by 4: operands visible during EXEC
    send(ins_ldi(3'd3, 9'h123));
    drain();
    send(ins_rr(4'h8, 3'd3, 3'd0, 4'd4));
    chk("sll_exec_op", {12'h0, alu_opcode}, 16'h0008);
    chk("sll_exec_immd", {12'h0, alu_immd}, 16'h0004);
    chk("sll_exec_rd", alu_rd, 16'h0123);
    drain();
    check_rf("sll_rf");

    // Back-to-back with in_valid held high
    stream[0] = ins_rr(4'h0, 3'd4, 3'd1, 4'd0);
    stream[1] = ins_ldi(3'd5, 9'h1FF);
    stream[2] = ins_rr(4'h5, 3'd5, 3'd4, 4'd0);
    stream[3] = 16'hF000;
    base = hs_cyc.size();
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int n;
      in_instr = stream[k];
      n = 0;
      while (hs_cyc.size() == base + k && n < 12) begin
        tick();
        n++;
      end
    end
    in_valid = 1'b0;
    chk("stream_count", 16'(hs_cyc.size() - base), 16'd4);
    drain();
    if (hs_cyc.size() == base + 4) begin
      for (int k = 0; k < 3; k++) begin
        chk("stream_spacing", 16'(hs_cyc[base + k + 1] - hs_cyc[base + k]), 16'd3);
      end
    end
    check_rf("stream_rf");

    // Reset during EXEC of ADD r1,r2 aborts it
    send(ins_rr(4'h0, 3'd1, 3'd2, 4'd0));
    #3;
    rst = 1'b1;
    #1;
    chk("abort_done", {15'h0, done}, 16'd0);
    chk("abort_alu_op", {12'h0, alu_opcode}, 16'h0);
    chk("abort_alu_rd", alu_rd, 16'h0);
    sb.delete();
    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
    m_flags = 4'h0;
    @(posedge clk);
    cyc++;
    #4;
    rst = 1'b0;
    tick();
    tick();
    tick();
    check_rf("abort_rf");

    // Normal operation after the abort
    send(ins_ldi(3'd7, 9'h0AA));
    drain();
    check_rf("post_rf");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
